mem_bus_sched: RTL and testbench
================================

// Module: mem_bus_sched
// PURPOSE
//  Single-port memory scheduler between the execute core and the external memory/IO bus.
//  Accepts the core's instruction-fetch, data-read and data-write requests, which are level-held.
//  Serialises them onto one req/ack bus with fixed priority, and returns single-cycle done pulses.
//  Enforces user-mode IO protection and a bus timeout, reporting violations on bus_fault.
// PARAMETERS
//  RV       32   datapath width (16 or 32)
//  VA       RV   virtual address width
//  TIMEOUT  255  cycles to wait for m_ack before aborting (1..255, 8-bit counter)
// PORTS
//  clk        in   1        clock
//  reset      in   1        asynchronous, active-high reset
//  ifetch     in   1        core instruction-fetch request (level, held until idone)
//  rstrobe    in   2        core read request, byte-lane strobes; nonzero = request (held until rdone)
//  wmask      in   RV/8     core write byte mask; nonzero = request (held until wdone)
//  pc         in   VA-1     fetch address, halfword units
//  addr       in   VA-RV/16 data address, word units
//  wdata      in   RV       write data
//  io_access  in   1        data access targets IO space
//  supmode    in   1        core in supervisor mode
//  user_io    in   1        user-mode IO permitted
//  idone      out  1        fetch complete (1-cycle pulse)
//  rdone      out  1        read complete (1-cycle pulse)
//  wdone      out  1        write complete (1-cycle pulse)
//  rdata      out  RV       registered read/fetch data, valid with idone/rdone
//  bus_fault  out  1        1-cycle pulse: timeout or IO protection violation
//  m_req      out  1        bus request, held until m_ack or abort
//  m_we       out  1        bus write
//  m_io       out  1        bus IO-space cycle
//  m_addr     out  VA       byte address
//  m_mask     out  RV/8     byte enables (reads: lane strobes expanded; fetch: all ones)
//  m_wdata    out  RV       write data
//  m_ack      in   1        bus cycle complete; m_rdata valid
//  m_rdata    in   RV       bus read data
// BEHAVIOUR
//  - Reset (async): state IDLE; all outputs 0; timeout counter 0. Reset mid-cycle drops m_req immediately.
//  - States: IDLE, FETCH, READ, WRITE, DONE.
//  - IDLE: sample requests with priority write > read > fetch. Register m_addr/m_mask/m_we/m_io/m_wdata.
//    Set m_req on the next edge. m_addr is {pc,1'b0} for fetch and {addr,{RV/16{1'b0}}} for data.
//  - Protection: a data request with io_access && !supmode && !user_io issues no bus cycle.
//    It goes straight to DONE with bus_fault pulsed and rdata = 0.
//  - FETCH/READ/WRITE: hold m_req and all m_* stable. The counter increments each cycle without m_ack.
//  - On m_ack: drop m_req, capture m_rdata into rdata (reads/fetch), go to DONE.
//  - If the counter reaches TIMEOUT without m_ack: drop m_req, set rdata = all ones, pulse bus_fault, go to DONE.
//  - m_ack in the same cycle as expiry: ack wins, no fault.
//  - DONE (1 cycle): pulse exactly one of idone/rdone/wdone for the served request, then return to IDLE.
//    The requester drops its level on that edge, so IDLE never re-serves a finished request.
//  - Minimum latency: request seen at cycle N, m_req at N+1, m_ack at N+1 gives done at N+2.
//  - Competing requests wait with no starvation guarantee beyond the core's one-outstanding discipline.
//  - m_ack while in IDLE/DONE is ignored.
//  - rdata holds its value between completions.
//  - RV=16: m_mask = rstrobe for reads; RV=32: lane = addr-selected strobe pattern passed through as {rstrobe,rstrobe}.
// TESTING
//  1. Fetch pc=0x10, m_ack after 3 cycles, m_rdata=0x12345678 -> m_addr=0x20, m_mask=4'hF;
//     idone one cycle after ack, rdata=0x12345678.
//  2. Write wmask=4'b0100, addr=0x5, wdata=0xAABBCCDD, ack at 1 cycle -> m_we=1, m_addr=0x14,
//     m_mask=4'b0100, wdone pulse, no idone/rdone.
//  3. ifetch and rstrobe=2'b11 raised together -> read served first (rdone),
//     then fetch (idone) without fetch re-issue glitch.
//  4. User read io_access=1, supmode=0, user_io=0 -> m_req never asserted;
//     bus_fault and rdone pulse together, rdata=0.
//  5. No m_ack, TIMEOUT=4 -> m_req high 4 cycles then low; bus_fault+rdone, rdata=all ones;
//     repeat with ack on expiry cycle -> no fault.
//  6. Assert reset while m_req high in WRITE -> m_req/wdone low immediately;
//     after release, IDLE serves the next request normally.

Source files
------------

// File: rtl/mem_bus_sched_if.sv
// mem_bus_sched_if: memory/IO bus (req/ack handshake, address, mask, data); master = scheduler, slave = memory
interface mem_bus_sched_if #(parameter int RV = 32, parameter int VA = RV) ();
  logic          m_req;
  logic          m_we;
  logic          m_io;
  logic [VA-1:0] m_addr;
  logic [RV/8-1:0] m_mask;
  logic [RV-1:0] m_wdata;
  logic          m_ack;
  logic [RV-1:0] m_rdata;
  modport master (output m_req, m_we, m_io, m_addr, m_mask, m_wdata, input m_ack, m_rdata);
  modport slave (input m_req, m_we, m_io, m_addr, m_mask, m_wdata, output m_ack, m_rdata);
endinterface

// File: rtl/mem_bus_sched.sv
// mem_bus_sched: serialises core fetch/read/write onto one req/ack bus (write>read>fetch) with IO protection, timeout, done pulses and rdata
module mem_bus_sched #(
  parameter int RV      = 32,
  parameter int VA      = RV,
  parameter int TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ifetch,
  input  logic [1:0]           rstrobe,
  input  logic [RV/8-1:0]      wmask,
  input  logic [VA-2:0]        pc,
  input  logic [VA-RV/16-1:0]  addr,
  input  logic [RV-1:0]        wdata,
  input  logic                 io_access,
  input  logic                 supmode,
  input  logic                 user_io,
  output logic                 idone,
  output logic                 rdone,
  output logic                 wdone,
  output logic [RV-1:0]        rdata,
  output logic                 bus_fault,
  mem_bus_sched_if.master      bus
);
  typedef enum logic [2:0] {IDLE, FETCH, READ, WRITE, DONE} state_t;
  state_t          state_q, state_d, kind_q, kind_d;
  logic [7:0]      cnt_q, cnt_d;
  logic            fault_q, fault_d, we_q, we_d, io_q, io_d;
  logic [RV-1:0]   rdata_q, rdata_d, wdata_q, wdata_d;
  logic [VA-1:0]   addr_q, addr_d;
  logic [RV/8-1:0] mask_q, mask_d;
  logic            wr, rd, data;
  assign wr   = |wmask;
  assign rd   = |rstrobe;
  assign data = wr | rd;
  always_comb begin
    state_d = state_q;
    kind_d  = kind_q;
    cnt_d   = cnt_q;
    fault_d = 1'b0;
    rdata_d = rdata_q;
    we_d    = we_q;
    io_d    = io_q;
    addr_d  = addr_q;
    mask_d  = mask_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE: if (data || ifetch) begin
        kind_d  = wr ? WRITE : rd ? READ : FETCH;
        we_d    = wr;
        io_d    = data & io_access;
        addr_d  = data ? {addr, {(RV/16){1'b0}}} : {pc, 1'b0};
        mask_d  = wr ? wmask : rd ? {(RV/16){rstrobe}} : '1;
        wdata_d = wr ? wdata : '0;
        cnt_d   = '0;
        // user-mode IO without permission never reaches the bus
        if (data && io_access && !supmode && !user_io) begin
          state_d = DONE;
          fault_d = 1'b1;
          rdata_d = '0;
        end else begin
          state_d = wr ? WRITE : rd ? READ : FETCH;
        end
      end
      FETCH, READ, WRITE: if (bus.m_ack) begin
        state_d = DONE;
        rdata_d = (state_q == WRITE) ? rdata_q : bus.m_rdata;
      end else if (cnt_q == 8'(TIMEOUT - 1)) begin
        state_d = DONE;
        fault_d = 1'b1;
        rdata_d = '1;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      kind_q  <= FETCH;
      cnt_q   <= '0;
      fault_q <= 1'b0;
      rdata_q <= '0;
      we_q    <= 1'b0;
      io_q    <= 1'b0;
      addr_q  <= '0;
      mask_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
      rdata_q <= rdata_d;
      we_q    <= we_d;
      io_q    <= io_d;
      addr_q  <= addr_d;
      mask_q  <= mask_d;
      wdata_q <= wdata_d;
    end
  end
  assign bus.m_req   = (state_q == FETCH) || (state_q == READ) || (state_q == WRITE);
  assign bus.m_we    = we_q;
  assign bus.m_io    = io_q;
  assign bus.m_addr  = addr_q;
  assign bus.m_mask  = mask_q;
  assign bus.m_wdata = wdata_q;
  assign idone       = (state_q == DONE) && (kind_q == FETCH);
  assign rdone       = (state_q == DONE) && (kind_q == READ);
  assign wdone       = (state_q == DONE) && (kind_q == WRITE);
  assign rdata       = rdata_q;
  assign bus_fault   = fault_q;
endmodule

// File: tb/tb_mem_bus_sched.sv
// tb_mem_bus_sched: directed vectors with hand-computed expectations for mem_bus_sched
module tb_mem_bus_sched;
  logic        clk = 1'b0, reset = 1'b1, ifetch = 1'b0, io_access = 1'b0, supmode = 1'b1, user_io = 1'b0;
  logic [1:0]  rstrobe = '0;
  logic [3:0]  wmask = '0;
  logic [30:0] pc = '0;
  logic [29:0] addr = '0;
  logic [31:0] wdata = '0, rdata;
  logic        idone, rdone, wdone, bus_fault;
  int          total = 0, bad = 0;
  mem_bus_sched_if #(.RV(32), .VA(32)) bus ();
  mem_bus_sched #(.RV(32), .VA(32), .TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .ifetch(ifetch), .rstrobe(rstrobe), .wmask(wmask), .pc(pc),
    .addr(addr), .wdata(wdata), .io_access(io_access), .supmode(supmode), .user_io(user_io),
    .idone(idone), .rdone(rdone), .wdone(wdone), .rdata(rdata), .bus_fault(bus_fault), .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    bus.m_ack = 1'b0;
    bus.m_rdata = '0;
    tick();
    tick();
    chk("rst_req", bus.m_req, 0);
    chk("rst_done", {idone, rdone, wdone, bus_fault}, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_addr", bus.m_addr, 0);
    reset = 1'b0;
    // fetch, ack on third bus cycle
    pc = 31'h10; ifetch = 1'b1;
    tick();
    chk("f_req", bus.m_req, 1);
    chk("f_addr", bus.m_addr, 32'h20);
    chk("f_mask", bus.m_mask, 4'hF);
    chk("f_we", bus.m_we, 0);
    tick();
    chk("f_hold", {bus.m_req, bus.m_addr}, {1'b1, 32'h20});
    tick();
    bus.m_ack = 1'b1; bus.m_rdata = 32'h12345678;
    tick();
    chk("f_done", {idone, rdone, wdone, bus_fault, bus.m_req}, 5'b10000);
    chk("f_rdata", rdata, 32'h12345678);
    ifetch = 1'b0; bus.m_ack = 1'b0;
    tick();
    chk("f_idle", {idone, bus.m_req}, 0);
    // write, ack on first bus cycle
    wmask = 4'b0100; addr = 30'h5; wdata = 32'hAABBCCDD;
    tick();
    chk("w_bus", {bus.m_req, bus.m_we, bus.m_io, bus.m_mask}, {3'b110, 4'b0100});
    chk("w_addr", bus.m_addr, 32'h14);
    chk("w_wdata", bus.m_wdata, 32'hAABBCCDD);
    bus.m_ack = 1'b1;
    tick();
    chk("w_done", {idone, rdone, wdone, bus_fault}, 4'b0010);
    chk("w_rdata_hold", rdata, 32'h12345678);
    wmask = '0; bus.m_ack = 1'b0;
    tick();
    // read beats fetch, then fetch served once
    ifetch = 1'b1; pc = 31'h40; rstrobe = 2'b11; addr = 30'h2;
    tick();
    chk("rf_rd_first", {bus.m_req, bus.m_we, bus.m_mask}, {2'b10, 4'hF});
    chk("rf_rd_addr", bus.m_addr, 32'h8);
    bus.m_ack = 1'b1; bus.m_rdata = 32'hCAFE0001;
    tick();
    chk("rf_rdone", {idone, rdone, wdone}, 3'b010);
    chk("rf_rdata", rdata, 32'hCAFE0001);
    rstrobe = '0; bus.m_ack = 1'b0;
    tick();
    chk("rf_idle_gap", bus.m_req, 0);
    tick();
    chk("rf_f_addr", {bus.m_req, bus.m_addr}, {1'b1, 32'h80});
    bus.m_ack = 1'b1; bus.m_rdata = 32'h0BADF00D;
    tick();
    chk("rf_idone", {idone, rdone, wdone}, 3'b100);
    chk("rf_f_rdata", rdata, 32'h0BADF00D);
    ifetch = 1'b0; bus.m_ack = 1'b0;
    tick();
    tick();
    chk("rf_no_reissue", {bus.m_req, idone}, 0);
    // supervisor IO read, single low lane pair
    rstrobe = 2'b01; io_access = 1'b1; addr = 30'h3;
    tick();
    chk("io_bus", {bus.m_req, bus.m_io, bus.m_mask}, {2'b11, 4'b0101});
    chk("io_addr", bus.m_addr, 32'hC);
    bus.m_ack = 1'b1; bus.m_rdata = 32'h00000042;
    tick();
    chk("io_done", {rdone, bus_fault, rdata}, {2'b10, 32'h42});
    rstrobe = '0; bus.m_ack = 1'b0;
    tick();
    // user-mode IO read without permission
    supmode = 1'b0; rstrobe = 2'b11;
    tick();
    chk("prot_done", {bus.m_req, rdone, bus_fault}, 3'b011);
    chk("prot_rdata", rdata, 0);
    rstrobe = '0; supmode = 1'b1; io_access = 1'b0;
    tick();
    chk("prot_clear", {bus.m_req, rdone, bus_fault}, 0);
    // m_ack in IDLE is ignored
    bus.m_ack = 1'b1; bus.m_rdata = 32'hDEADBEEF;
    tick();
    chk("idle_ack", {bus.m_req, idone, rdone, wdone, rdata}, 36'h0);
    bus.m_ack = 1'b0;
    // timeout with no ack
    rstrobe = 2'b11;
    tick();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("to_req%0d", i), bus.m_req, 1);
      tick();
    end
    chk("to_done", {bus.m_req, rdone, bus_fault}, 3'b011);
    chk("to_rdata", rdata, 32'hFFFFFFFF);
    rstrobe = '0;
    tick();
    chk("to_clear", {bus_fault, rdone}, 0);
    // ack on the expiry cycle wins
    rstrobe = 2'b11;
    tick();
    for (int i = 0; i < 3; i++) tick();
    chk("tx_req", bus.m_req, 1);
    bus.m_ack = 1'b1; bus.m_rdata = 32'h55AA55AA;
    tick();
    chk("tx_done", {bus.m_req, rdone, bus_fault}, 3'b010);
    chk("tx_rdata", rdata, 32'h55AA55AA);
    rstrobe = '0; bus.m_ack = 1'b0;
    tick();
    // async reset during write
    wmask = 4'hF; addr = 30'h1; wdata = 32'h11;
    tick();
    chk("rw_req", bus.m_req, 1);
    #2 reset = 1'b1;
    #1;
    chk("rw_async", {bus.m_req, wdone, idone, rdone}, 0);
    chk("rw_rdata", rdata, 0);
    wmask = '0;
    #1 reset = 1'b0;
    tick();
    chk("rw_idle", {bus.m_req, wdone}, 0);
    pc = 31'h8; ifetch = 1'b1;
    tick();
    chk("rw_fetch", {bus.m_req, bus.m_addr}, {1'b1, 32'h10});
    bus.m_ack = 1'b1; bus.m_rdata = 32'h77;
    tick();
    chk("rw_idone", {idone, wdone, rdata}, {2'b10, 32'h77});
    ifetch = 1'b0; bus.m_ack = 1'b0;
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
